// File: rtl/result_writeback_regfile_pkg.sv
// Shared constants for the writeback register file.
// Holds default sizes, the x0 value and the write-counter width.
package result_writeback_regfile_pkg;

    localparam int RF_XLEN    = 32;
    localparam int RF_NREGS   = 32;
    localparam int RF_AW      = 5;
    localparam int RF_WRCNT_W = 16;

    localparam logic [RF_XLEN-1:0] REG_ZERO = '0;

    // A write only lands when out of reset, enabled and not aimed at x0.
    function automatic logic rf_commit(
        input logic             rst_n,
        input logic             we,
        input logic [RF_AW-1:0] addr
    );
        return rst_n && we && (addr != '0);
    endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: address -> data, x0 forced to zero,
// optional same-cycle forwarding of the pending write.
// Ports: regs (flattened storage), addr, wr_en/wr_addr/wr_data (pending
//        write, already qualified by reset), rd_data.
module regfile_read_port
    import result_writeback_regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int AW     = RF_AW,
    parameter int BYPASS = 0
) (
    input  logic [NREGS-1:0][XLEN-1:0] regs,
    input  logic [AW-1:0]              addr,
    input  logic                       wr_en,
    input  logic [AW-1:0]              wr_addr,
    input  logic [XLEN-1:0]            wr_data,
    output logic [XLEN-1:0]            rd_data
);

    logic fwd;

    always_comb begin
        fwd = (BYPASS != 0) && wr_en
              && (wr_addr != '0) && (wr_addr == addr);

        rd_data = regs[addr];
        if (addr == '0) begin
            rd_data = XLEN'(REG_ZERO);
        end
        if (fwd) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/result_writeback_regfile.sv
// Integer register file at the receiving end of the writeback path.
// Ports: clk, reset (sync, active-low), RegWrite/A3/WD3 write port,
//        A1/RD1 and A2/RD2 operand reads, DbgA/DbgRD debug read,
//        WrCount committed-write counter (x0 writes not counted).
module result_writeback_regfile
    import result_writeback_regfile_pkg::*;
#(
    parameter int XLEN   = RF_XLEN,
    parameter int NREGS  = RF_NREGS,
    parameter int AW     = RF_AW,
    parameter int BYPASS = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  RegWrite,
    input  logic [AW-1:0]         A1,
    input  logic [AW-1:0]         A2,
    input  logic [AW-1:0]         A3,
    input  logic [XLEN-1:0]       WD3,
    output logic [XLEN-1:0]       RD1,
    output logic [XLEN-1:0]       RD2,
    input  logic [AW-1:0]         DbgA,
    output logic [XLEN-1:0]       DbgRD,
    output logic [RF_WRCNT_W-1:0] WrCount
);

    logic [NREGS-1:0][XLEN-1:0] regs_q;
    logic [NREGS-1:0][XLEN-1:0] regs_d;
    logic [RF_WRCNT_W-1:0]      wr_count_q;
    logic [RF_WRCNT_W-1:0]      wr_count_d;
    logic                       commit;

    always_comb begin
        commit     = reset && RegWrite && (A3 != '0);
        regs_d     = regs_q;
        wr_count_d = wr_count_q;
        if (commit) begin
            regs_d[A3] = WD3;
            wr_count_d = wr_count_q + RF_WRCNT_W'(1);
        end
    end

    // Reset wins over any write presented in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_q     <= '0;
            wr_count_q <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_count_q <= wr_count_d;
        end
    end

    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW),
        .BYPASS(BYPASS)
    ) u_rp1 (
        .regs   (regs_q),
        .addr   (A1),
        .wr_en  (commit),
        .wr_addr(A3),
        .wr_data(WD3),
        .rd_data(RD1)
    );

    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW),
        .BYPASS(BYPASS)
    ) u_rp2 (
        .regs   (regs_q),
        .addr   (A2),
        .wr_en  (commit),
        .wr_addr(A3),
        .wr_data(WD3),
        .rd_data(RD2)
    );

    // Debug port always shows committed state only.
    regfile_read_port #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .AW    (AW),
        .BYPASS(0)
    ) u_rpd (
        .regs   (regs_q),
        .addr   (DbgA),
        .wr_en  (1'b0),
        .wr_addr(A3),
        .wr_data(WD3),
        .rd_data(DbgRD)
    );

    assign WrCount = wr_count_q;

endmodule

// File: tb/tb_result_writeback_regfile.sv
// Bench for result_writeback_regfile: a plain build and a forwarding
// build share stimulus and are checked against an array model.
module tb_result_writeback_regfile;

    logic        clk;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  A1, A2, A3, DbgA;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2, DbgRD;
    logic [31:0] bRD1, bRD2, bDbgRD;
    logic [15:0] WrCount, bWrCount;

    logic [31:0] mem [32];
    logic [15:0] cnt;
    int          n_assert;
    int          n_fail;

    result_writeback_regfile u0 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2), .DbgA(DbgA), .DbgRD(DbgRD),
        .WrCount(WrCount)
    );

    result_writeback_regfile #(.BYPASS(1)) u1 (
        .clk(clk), .reset(reset), .RegWrite(RegWrite),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .RD1(bRD1), .RD2(bRD2), .DbgA(DbgA), .DbgRD(bDbgRD),
        .WrCount(bWrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value from the architectural state plus the
    // pending write when forwarding is enabled.
    function automatic logic [31:0] ref_rd(input logic [4:0] a,
                                           input bit byp);
        if (byp && reset && RegWrite && A3 != 0 && A3 == a)
            return WD3;
        if (a == 0)
            return 32'h0;
        return mem[a];
    endfunction

    task automatic check_all();
        chk("rd1",      RD1,      ref_rd(A1, 0));
        chk("rd2",      RD2,      ref_rd(A2, 0));
        chk("dbg",      DbgRD,    ref_rd(DbgA, 0));
        chk("cnt",      {16'h0, WrCount},  {16'h0, cnt});
        chk("byp_rd1",  bRD1,     ref_rd(A1, 1));
        chk("byp_rd2",  bRD2,     ref_rd(A2, 1));
        chk("byp_dbg",  bDbgRD,   ref_rd(DbgA, 0));
        chk("byp_cnt",  {16'h0, bWrCount}, {16'h0, cnt});
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem[i] = 32'h0;
            cnt = 16'h0;
        end else if (RegWrite && A3 != 0) begin
            mem[A3] = WD3;
            cnt = cnt + 16'd1;
        end
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWrite = 1'b1; A3 = a; WD3 = d;
        A1 = a; A2 = a; DbgA = a;
        #1 check_all();
        tick();
        RegWrite = 1'b0;
        #1 check_all();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        cnt      = 16'h0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;

        // Reset held two edges with a competing write.
        reset = 1'b0; RegWrite = 1'b1; A3 = 5'd5; WD3 = 32'hDEADBEEF;
        A1 = 5'd5; A2 = 5'd0; DbgA = 5'd0;
        tick();
        tick();
        reset = 1'b1; RegWrite = 1'b0;
        for (int i = 0; i < 32; i++) begin
            DbgA = 5'(i);
            #1 chk("rst_dbg", DbgRD, 32'h0);
        end
        chk("rst_cnt", {16'h0, WrCount}, 32'h0);

        // Write x5: old value before the edge, new value after.
        RegWrite = 1'b1; A3 = 5'd5; WD3 = 32'h12345678;
        A1 = 5'd5; A2 = 5'd5; DbgA = 5'd5;
        #1;
        chk("pre_rd1", RD1, 32'h0);
        chk("pre_rd2", RD2, 32'h0);
        check_all();
        tick();
        RegWrite = 1'b0;
        #1;
        chk("post_rd1", RD1, 32'h12345678);
        chk("post_rd2", RD2, 32'h12345678);
        chk("post_cnt", {16'h0, WrCount}, 32'd1);

        // x0 stays zero and the write is not counted.
        RegWrite = 1'b1; A3 = 5'd0; WD3 = 32'hFFFFFFFF;
        A1 = 5'd0; A2 = 5'd0; DbgA = 5'd0;
        tick();
        RegWrite = 1'b0;
        #1;
        chk("x0_rd1", RD1, 32'h0);
        chk("x0_cnt", {16'h0, WrCount}, 32'd1);

        // ALU / load / PC+4 style results into x1..x3.
        wr(5'd1, 32'h00000010);
        wr(5'd2, 32'hCAFEF00D);
        wr(5'd3, 32'h00000104);
        A1 = 5'd1; A2 = 5'd2; DbgA = 5'd3;
        #1;
        chk("mix_x1", RD1, 32'h00000010);
        chk("mix_x2", RD2, 32'hCAFEF00D);
        chk("mix_x3", DbgRD, 32'h00000104);
        chk("mix_cnt", {16'h0, WrCount}, 32'd4);

        // Same-cycle forwarding in the bypass build only.
        RegWrite = 1'b1; A3 = 5'd9; WD3 = 32'h0BADF00D;
        A1 = 5'd9; A2 = 5'd1; DbgA = 5'd9;
        #1;
        chk("byp_same", bRD1, 32'h0BADF00D);
        chk("byp_dbg_old", bDbgRD, 32'h0);
        chk("nobyp_old", RD1, 32'h0);
        check_all();
        tick();
        RegWrite = 1'b0;
        #1;
        chk("byp_dbg_new", bDbgRD, 32'h0BADF00D);

        // Reset coincident with a write to x7.
        reset = 1'b0; RegWrite = 1'b1; A3 = 5'd7; WD3 = 32'hAAAA5555;
        tick();
        reset = 1'b1; RegWrite = 1'b0; A1 = 5'd7; A2 = 5'd9;
        #1;
        chk("mid_x7", RD1, 32'h0);
        chk("mid_x9", RD2, 32'h0);
        chk("mid_cnt", {16'h0, WrCount}, 32'h0);
        for (int i = 0; i < 32; i++) begin
            DbgA = 5'(i);
            #1 chk("mid_dbg", DbgRD, 32'h0);
        end

        // Random traffic with rare resets and frequent address reuse.
        for (int n = 0; n < 400; n++) begin
            reset    = ($urandom_range(0, 39) != 0);
            RegWrite = $urandom_range(0, 3) != 0;
            A3       = 5'($urandom_range(0, 9));
            WD3      = $urandom;
            A1 = ($urandom_range(0, 2) == 0) ? A3
                 : 5'($urandom_range(0, 9));
            A2 = ($urandom_range(0, 2) == 0) ? A3
                 : 5'($urandom_range(0, 31));
            DbgA = ($urandom_range(0, 1) == 0) ? A3
                   : 5'($urandom_range(0, 31));
            #1 check_all();
            tick();
        end
        reset = 1'b1; RegWrite = 1'b0;
        #1 check_all();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
